// File: rtl/cbuf_fill_parser.sv
// cbuf_fill_parser: walks a stream of tagged 132-bit words through one fill
// (fill header, waveform header, num_bursts data words, checksum), latches the
// header fields, unpacks eight 12-bit samples per data word, keeps a running
// XOR checksum over payloads and records sticky protocol errors.
//
// Handshake: a word transfers on a rising edge where valid and ready are both
// high. A producer keeps valid and its data stable until that edge. Ready may
// depend on the other side's state but never on valid. in_ready drops only
// while a sample beat is waiting for samp_ready, so every word type stalls
// behind an unconsumed sample.
module cbuf_fill_parser #(
  parameter int CHK_SEXT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [131:0] in_dat,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [23:0]  fill_num,
  output logic [13:0]  num_bursts,
  output logic [15:0]  pre_trig,
  output logic [25:0]  start_adr,
  output logic [11:0]  channel_tag,
  output logic [3:0]   xadc_alarms,
  output logic [95:0]  samp_dat,
  output logic         samp_valid,
  input  logic         samp_ready,
  output logic         fill_done,
  output logic         cksum_ok,
  output logic [4:0]   err,
  input  logic         err_clr,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    FILL_HDR = 2'd0,
    WFM_HDR  = 2'd1,
    DATA     = 2'd2,
    CKSUM    = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [3:0]     tag;
  logic [127:0]   pl;
  logic           accept;
  logic [127:0]   cksum_acc;
  logic [13:0]    cnt;

  logic           do_fill;
  logic           do_wfm;
  logic           do_data;
  logic           do_ck;
  logic [4:0]     err_set;
  logic           mark_bad;
  logic           fill_field_bad;
  logic           wfm_field_bad;
  logic           sext_any;
  logic           sext_bad;
  logic [95:0]    samp_pack;

  assign tag       = in_dat[131:128];
  assign pl        = in_dat[127:0];
  assign in_ready  = !(samp_valid && !samp_ready);
  assign accept    = in_valid && in_ready;
  assign dbg_state = state;

  // Word decode: header marker, header field consistency, sample unpacking and sign-extension check.
  always_comb begin
    mark_bad       = (pl[127:126] != 2'b01);
    fill_field_bad = (pl[122] != 1'b1) || (pl[87:76] != 12'd1);
    wfm_field_bad  = (pl[114] != 1'b1)
                  || (pl[13:0] != num_bursts)
                  || ({pl[78:75], pl[25:14]} != pre_trig)
                  || (pl[51:26] != start_adr)
                  || (pl[74:52] != 23'd1)
                  || (pl[109:98] != channel_tag);
    sext_any  = 1'b0;
    samp_pack = '0;
    for (int k = 0; k < 8; k++) begin
      samp_pack[12*k +: 12] = pl[16*k +: 12];
      if (pl[16*k+12 +: 4] != {4{pl[16*k+11]}}) sext_any = 1'b1;
    end
    sext_bad = (CHK_SEXT != 0) && sext_any;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FILL_HDR;
    else     state <= state_nx;
  end

  // Next state and per-word actions; a tag-1 word always starts a new fill.
  always_comb begin
    state_nx = state;
    do_fill  = 1'b0;
    do_wfm   = 1'b0;
    do_data  = 1'b0;
    do_ck    = 1'b0;
    err_set  = 5'd0;
    if (accept) begin
      if (tag == 4'd1) begin
        do_fill  = 1'b1;
        state_nx = WFM_HDR;
        if (state != FILL_HDR) err_set[1] = 1'b1;
        if (mark_bad)          err_set[2] = 1'b1;
        if (fill_field_bad)    err_set[3] = 1'b1;
      end else begin
        case (state)
          FILL_HDR: err_set[1] = 1'b1;
          WFM_HDR: begin
            if (tag == 4'd2) begin
              do_wfm   = 1'b1;
              state_nx = (num_bursts == 14'd0) ? CKSUM : DATA;
              if (mark_bad)      err_set[2] = 1'b1;
              if (wfm_field_bad) err_set[3] = 1'b1;
            end else begin
              err_set[1] = 1'b1;
              state_nx   = FILL_HDR;
            end
          end
          DATA: begin
            if (tag == 4'd3) begin
              do_data  = 1'b1;
              state_nx = (cnt == 14'd1) ? CKSUM : DATA;
              if (sext_bad) err_set[4] = 1'b1;
            end else begin
              err_set[1] = 1'b1;
              state_nx   = FILL_HDR;
            end
          end
          CKSUM: begin
            if (tag == 4'd4) begin
              do_ck    = 1'b1;
              state_nx = FILL_HDR;
              if (pl != cksum_acc) err_set[0] = 1'b1;
            end else begin
              err_set[1] = 1'b1;
              state_nx   = FILL_HDR;
            end
          end
          default: state_nx = FILL_HDR;
        endcase
      end
    end
  end

  // Datapath: field latches, checksum accumulator, burst counter, sample register, sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      fill_num    <= '0;
      num_bursts  <= '0;
      pre_trig    <= '0;
      start_adr   <= '0;
      channel_tag <= '0;
      xadc_alarms <= '0;
      samp_dat    <= '0;
      samp_valid  <= 1'b0;
      fill_done   <= 1'b0;
      cksum_ok    <= 1'b0;
      err         <= '0;
      cksum_acc   <= '0;
      cnt         <= '0;
    end else begin
      fill_done <= do_ck;
      if (do_ck) cksum_ok <= (pl == cksum_acc);
      if (do_fill) begin
        fill_num    <= pl[23:0];
        num_bursts  <= pl[40:27];
        pre_trig    <= pl[103:88];
        start_adr   <= pl[75:50];
        channel_tag <= pl[121:110];
        cksum_acc   <= pl;
      end
      if (do_wfm) begin
        cksum_acc   <= cksum_acc ^ pl;
        xadc_alarms <= pl[113:110];
        cnt         <= num_bursts;
      end
      if (do_data) begin
        cksum_acc  <= cksum_acc ^ pl;
        cnt        <= cnt - 14'd1;
        samp_dat   <= samp_pack;
        samp_valid <= 1'b1;
      end else if (samp_ready) begin
        samp_valid <= 1'b0;
      end
      if (err_clr) err <= '0;
      else         err <= err | err_set;
    end
  end

endmodule

// File: tb/tb_cbuf_fill_parser.sv
// Bench for cbuf_fill_parser: builds whole fills from randomized fields and
// samples, derives the expected sample beats, checksum verdicts and error
// flags from how each fill was constructed, and checks them in a decoupled
// monitor.
module tb_cbuf_fill_parser;

  localparam int CHK = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [131:0] in_dat = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [23:0]  fill_num;
  logic [13:0]  num_bursts;
  logic [15:0]  pre_trig;
  logic [25:0]  start_adr;
  logic [11:0]  channel_tag;
  logic [3:0]   xadc_alarms;
  logic [95:0]  samp_dat;
  logic         samp_valid;
  logic         samp_ready = 1'b1;
  logic         fill_done;
  logic         cksum_ok;
  logic [4:0]   err;
  logic         err_clr = 1'b0;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0 random, 1 forced low, 2 forced high

  logic [95:0] samp_q[$];
  bit          done_q[$];
  logic [95:0] dir_q[$];

  logic [23:0] m_fill;
  logic [13:0] m_nb;
  logic [15:0] m_pre;
  logic [25:0] m_adr;
  logic [11:0] m_chan;
  logic [3:0]  m_alarm;
  logic [4:0]  m_err = '0;

  cbuf_fill_parser #(.CHK_SEXT(CHK)) dut (
    .clk(clk), .rst(rst), .in_dat(in_dat), .in_valid(in_valid), .in_ready(in_ready),
    .fill_num(fill_num), .num_bursts(num_bursts), .pre_trig(pre_trig),
    .start_adr(start_adr), .channel_tag(channel_tag), .xadc_alarms(xadc_alarms),
    .samp_dat(samp_dat), .samp_valid(samp_valid), .samp_ready(samp_ready),
    .fill_done(fill_done), .cksum_ok(cksum_ok), .err(err), .err_clr(err_clr),
    .dbg_state(dbg_state)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Consumer ready, changed away from the sampling point.
  always @(negedge clk) begin
    #2;
    case (ready_mode)
      1:       samp_ready = 1'b0;
      2:       samp_ready = 1'b1;
      default: samp_ready = ($urandom_range(0, 99) < 70);
    endcase
  end

  // Monitor: pops expectations whenever the DUT presents a beat or a done pulse.
  always @(negedge clk) begin
    logic [95:0] es;
    bit          ed;
    #4;
    if (!rst) begin
      if (samp_valid && samp_ready) begin
        checks++;
        if (samp_q.size() == 0) begin
          errors++;
          $display("FAIL samp_unexpected actual=%0h required=none", samp_dat);
        end else begin
          es = samp_q.pop_front();
          if (samp_dat !== es) begin
            errors++;
            $display("FAIL samp_dat actual=%0h required=%0h", samp_dat, es);
          end
        end
      end
      if (fill_done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL fill_done_unexpected actual=1 required=0");
        end else begin
          ed = done_q.pop_front();
          if (cksum_ok !== ed) begin
            errors++;
            $display("FAIL cksum_ok actual=%0b required=%0b", cksum_ok, ed);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_fields(input int nb);
    m_fill  = 24'($urandom);
    m_nb    = 14'(nb);
    m_pre   = 16'($urandom);
    m_adr   = 26'($urandom);
    m_chan  = 12'($urandom);
    m_alarm = 4'($urandom);
  endtask

  function automatic logic [131:0] fill_word();
    logic [127:0] p;
    p = rnd128();
    p[127:126] = 2'b01;
    p[122]     = 1'b1;
    p[121:110] = m_chan;
    p[103:88]  = m_pre;
    p[87:76]   = 12'd1;
    p[75:50]   = m_adr;
    p[40:27]   = m_nb;
    p[23:0]    = m_fill;
    return {4'd1, p};
  endfunction

  function automatic logic [131:0] wfm_word();
    logic [127:0] p;
    p = rnd128();
    p[127:126] = 2'b01;
    p[114]     = 1'b1;
    p[113:110] = m_alarm;
    p[109:98]  = m_chan;
    p[78:75]   = m_pre[15:12];
    p[74:52]   = 23'd1;
    p[51:26]   = m_adr;
    p[25:14]   = m_pre[11:0];
    p[13:0]    = m_nb;
    return {4'd2, p};
  endfunction

  // Eight sign-extended 16-bit lanes; a bad lane has its four sign bits inverted.
  function automatic logic [131:0] data_word(input logic [95:0] s, input int bad_lane);
    logic [127:0] p;
    logic [11:0]  v;
    for (int k = 0; k < 8; k++) begin
      v = s[12*k +: 12];
      p[16*k +: 16] = {{4{v[11]}}, v};
    end
    if (bad_lane >= 0) p[16*bad_lane+12 +: 4] = ~p[16*bad_lane+12 +: 4];
    return {4'd3, p};
  endfunction

  // Driver: hold the word until it is accepted on an edge with in_ready high.
  task automatic send_word(input logic [131:0] w);
    bit ok;
    int n;
    ok = 1'b0;
    n  = 0;
    @(negedge clk); #1;
    in_dat   = w;
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      #3;
      ok = in_ready;
      @(posedge clk);
      n++;
      if (!ok) begin
        @(negedge clk); #1;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout actual=stalled required=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((samp_q.size() != 0 || done_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain_samp_q", 128'(samp_q.size()), 128'd0);
    chk("drain_done_q", 128'(done_q.size()), 128'd0);
  endtask

  task automatic end_check();
    drain();
    #4;
    chk("err",         128'(err),         128'(m_err));
    chk("fill_num",    128'(fill_num),    128'(m_fill));
    chk("num_bursts",  128'(num_bursts),  128'(m_nb));
    chk("pre_trig",    128'(pre_trig),    128'(m_pre));
    chk("start_adr",   128'(start_adr),   128'(m_adr));
    chk("channel_tag", 128'(channel_tag), 128'(m_chan));
    chk("xadc_alarms", 128'(xadc_alarms), 128'(m_alarm));
    @(negedge clk); #1;
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    @(negedge clk); #4;
    chk("err_after_clr", 128'(err), 128'd0);
    m_err = '0;
  endtask

  task automatic reset_mid();
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    samp_q.delete();
    done_q.delete();
    chk("rst_samp_valid", 128'(samp_valid), 128'd0);
    chk("rst_samp_dat",   128'(samp_dat),   128'd0);
    chk("rst_in_ready",   128'(in_ready),   128'd1);
    chk("rst_err",        128'(err),        128'd0);
    chk("rst_fields",     128'({fill_num, num_bursts, pre_trig, start_adr, channel_tag, xadc_alarms}), 128'd0);
    chk("rst_done_ok",    128'({fill_done, cksum_ok}), 128'd0);
    m_err = '0;
    ready_mode = 0;
  endtask

  // One fill built from its parts; bad_mark/bad_field select which header word to spoil.
  task automatic run_fill(input int nb, input int flip, input int bad_mark, input int bad_field,
                          input int bad_lane, input int bp_at, input int rst_at);
    logic [131:0] w;
    logic [127:0] acc;
    logic [127:0] ck;
    logic [95:0]  s;
    new_fields(nb);
    w = fill_word();
    if (bad_mark == 1)  begin w[127:126] = 2'b10; m_err[2] = 1'b1; end
    if (bad_field == 1) begin w[122] = 1'b0;      m_err[3] = 1'b1; end
    acc = w[127:0];
    send_word(w);
    w = wfm_word();
    if (bad_mark == 2)  begin w[127:126] = 2'b00;   m_err[2] = 1'b1; end
    if (bad_field == 2) begin w[74:52] = 23'd2;     m_err[3] = 1'b1; end
    if (bad_field == 3) begin w[109:98] = ~m_chan;  m_err[3] = 1'b1; end
    acc = acc ^ w[127:0];
    send_word(w);
    for (int i = 0; i < nb; i++) begin
      if (dir_q.size() != 0) s = dir_q.pop_front();
      else s = {$urandom, $urandom, $urandom};
      w = data_word(s, (i == 0) ? bad_lane : -1);
      if (i == 0 && bad_lane >= 0 && CHK != 0) m_err[4] = 1'b1;
      acc = acc ^ w[127:0];
      if (i == bp_at || i == rst_at) ready_mode = 2;
      samp_q.push_back(s);
      send_word(w);
      if (i == rst_at) begin
        ready_mode = 1;
        reset_mid();
        return;
      end
      if (i == bp_at) begin
        ready_mode = 1;
        @(negedge clk); #4;
        chk("bp_in_ready", 128'(in_ready), 128'd0);
        chk("bp_samp_valid", 128'(samp_valid), 128'd1);
        repeat (4) @(negedge clk);
        ready_mode = 0;
      end
    end
    ck = acc;
    if (flip >= 0) begin
      ck[flip] = ~ck[flip];
      m_err[0] = 1'b1;
    end
    done_q.push_back(flip < 0);
    send_word({4'd4, ck});
  endtask

  // Header, waveform header and a few data words of a fill that never finishes.
  task automatic partial_fill(input int nb, input int ndata);
    logic [95:0] s;
    new_fields(nb);
    send_word(fill_word());
    send_word(wfm_word());
    for (int i = 0; i < ndata; i++) begin
      s = {$urandom, $urandom, $urandom};
      samp_q.push_back(s);
      send_word(data_word(s, -1));
    end
  endtask

  initial begin
    logic [95:0] s1;
    logic [95:0] s2;
    int nb;
    int fl;
    int bl;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk); #4;
    chk("reset_in_ready",   128'(in_ready),   128'd1);
    chk("reset_samp_valid", 128'(samp_valid), 128'd0);
    chk("reset_err",        128'(err),        128'd0);
    chk("reset_fields",     128'({fill_num, num_bursts, pre_trig, start_adr, channel_tag, xadc_alarms}), 128'd0);
    chk("reset_done_ok",    128'({fill_done, cksum_ok}), 128'd0);

    for (int k = 0; k < 8; k++) begin
      s1[12*k +: 12] = 12'(k + 1);
      s2[12*k +: 12] = 12'(12'hFFF - k);
    end

    // Two-burst fill with a correct checksum, then the same with bit 0 flipped.
    dir_q.push_back(s1); dir_q.push_back(s2);
    run_fill(2, -1, 0, 0, -1, -1, -1);
    end_check();
    dir_q.push_back(s1); dir_q.push_back(s2);
    run_fill(2, 0, 0, 0, -1, -1, -1);
    end_check();

    // Zero bursts: header, waveform header, checksum.
    run_fill(0, -1, 0, 0, -1, -1, -1);
    end_check();

    // Lane 2 carries 0x0800: sample delivered, sign-extension flag set.
    s1 = {$urandom, $urandom, $urandom};
    s1[24 +: 12] = 12'h800;
    dir_q.push_back(s1);
    run_fill(1, -1, 0, 0, 2, -1, -1);
    end_check();

    // New fill header arriving after 1 of 3 data words.
    partial_fill(3, 1);
    m_err[1] = 1'b1;
    run_fill(1, -1, 0, 0, -1, -1, -1);
    end_check();

    // Early checksum word in DATA, then illegal tags while idle.
    partial_fill(2, 1);
    send_word({4'd4, rnd128()});
    send_word({4'd7, rnd128()});
    send_word({4'd3, rnd128()});
    m_err[1] = 1'b1;
    run_fill(1, -1, 0, 0, -1, -1, -1);
    end_check();

    // Clear wins over a same-cycle error set.
    @(negedge clk); #1;
    err_clr  = 1'b1;
    in_dat   = {4'd9, rnd128()};
    in_valid = 1'b1;
    @(posedge clk); #1;
    err_clr  = 1'b0;
    in_valid = 1'b0;
    @(negedge clk); #4;
    chk("clr_priority_err", 128'(err), 128'd0);

    // Consumer stalls for five cycles mid-DATA.
    run_fill(4, -1, 0, 0, -1, 1, -1);
    end_check();

    // Reset in the middle of DATA with a sample pending, then a clean fill.
    run_fill(3, -1, 0, 0, -1, -1, 1);
    run_fill(2, -1, 0, 0, -1, -1, -1);
    end_check();

    // Randomized fills with occasional checksum, marker, field and sign errors.
    for (int i = 0; i < 25; i++) begin
      nb = $urandom_range(0, 5);
      fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : -1;
      bl = (nb > 0 && $urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : -1;
      run_fill(nb, fl,
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0,
               ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0,
               bl, -1, -1);
      if (i % 5 == 4) end_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
